// File: rtl/int_to_float.sv
// int_to_float
//
// Sequential converter from a 64-bit signed two's-complement integer to an
// IEEE-754 single-precision float. One conversion is in flight at a time.
// The magnitude is normalised one bit per cycle. A final cycle then rounds
// to nearest, ties to even.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   inTrigger  start converting inData on this edge. This also aborts and
//              restarts a conversion that is already running.
//   inData     64-bit signed operand
//   outReady   1 = idle and outData valid, 0 = conversion in progress
//   outData    registered result {sign, exp[7:0], mant[22:0]}
//
// Latency for a nonzero operand whose magnitude has lz leading zeros:
// outReady rises on edge lz+2 after the trigger edge. For a zero operand,
// outReady is already 1 after the trigger edge.

module int_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic        inTrigger,
    input  logic [63:0] inData,
    output logic        outReady,
    output logic [31:0] outData
);

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound
    } state_e;

    // Exponent of a magnitude whose leading one sits at bit 63 (127 + 63).
    localparam logic [7:0] ExpTop = 8'd190;

    state_e      state_q, state_d;
    logic [63:0] mag_q,   mag_d;
    logic [7:0]  exp_q,   exp_d;
    logic        sign_q,  sign_d;
    logic        ready_q, ready_d;
    logic [31:0] data_q,  data_d;

    // Operand magnitude. For the most negative value, the two's-complement
    // negation wraps back to 0x8000_0000_0000_0000. Read as unsigned, that is
    // exactly 2^63, so no special case is needed.
    logic [63:0] abs_val;
    assign abs_val = inData[63] ? (~inData + 64'd1) : inData;

    // Rounding datapath. It is only meaningful in StRound, where mag_q[63] = 1.
    // Once mag_q is normalised, the hidden bit is mag_q[63] and the 23 stored
    // fraction bits follow it directly.
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;
    logic        frac_carry;

    assign frac       = mag_q[62:40];
    assign guard      = mag_q[39];
    assign sticky     = |mag_q[38:0];
    assign round_up   = guard & (sticky | frac[0]);
    assign frac_sum   = {1'b0, frac} + {23'd0, round_up};
    // When the fraction is all ones and rounds up, the mantissa wraps to zero
    // and the exponent bumps by one. This peaks at 190 (from 189), so the
    // result can never reach the Inf encoding.
    assign frac_carry = frac_sum[23];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mag_q   <= 64'd0;
            exp_q   <= 8'd0;
            sign_q  <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        ready_d = ready_q;
        data_d  = data_q;

        if (inTrigger) begin
            // A trigger takes effect in every state. A conversion already
            // in flight is dropped without producing a result.
            sign_d = inData[63];
            mag_d  = abs_val;
            exp_d  = ExpTop;
            if (inData == 64'd0) begin
                // Zero has no leading one to normalise. Answer +0 at once
                // so the converter never produces -0.
                data_d  = 32'd0;
                ready_d = 1'b1;
                state_d = StIdle;
            end else begin
                ready_d = 1'b0;
                state_d = StNorm;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Hold the result until the next trigger.
                end
                StNorm: begin
                    if (mag_q[63]) begin
                        state_d = StRound;
                    end else begin
                        // No more than 63 shifts occur for a nonzero
                        // operand, so exp stays at or above 127.
                        mag_d = {mag_q[62:0], 1'b0};
                        exp_d = exp_q - 8'd1;
                    end
                end
                StRound: begin
                    data_d  = {sign_q, exp_q + {7'd0, frac_carry}, frac_sum[22:0]};
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign outReady = ready_q;
    assign outData  = data_q;

endmodule

// File: tb/tb_int_to_float.sv
// Directed testbench for int_to_float. Every expected result and latency
// below was worked out by hand from the IEEE-754 encoding. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.

module tb_int_to_float;

    logic        clk;
    logic        rst;
    logic        inTrigger;
    logic [63:0] inData;
    logic        outReady;
    logic [31:0] outData;

    int unsigned passed;
    int unsigned total;

    int_to_float dut (
        .clk       (clk),
        .rst       (rst),
        .inTrigger (inTrigger),
        .inData    (inData),
        .outReady  (outReady),
        .outData   (outData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Apply a single-edge trigger, then count the edges until outReady is
    // seen high. A latency of 0 means outReady was already high after the
    // trigger edge.
    task automatic convert(input string tag, input logic [63:0] val,
                           input logic [31:0] exp_data, input int exp_lat);
        int n;
        inTrigger = 1'b1;
        inData    = val;
        tick();
        inTrigger = 1'b0;
        n = 0;
        while (!outReady && n < 200) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " data"}, {32'd0, outData}, {32'd0, exp_data});
    endtask

    initial begin
        logic [31:0] held;
        int          n;
        bit          spurious;

        rst       = 1'b1;
        inTrigger = 1'b0;
        inData    = 64'd0;
        tick();
        tick();
        check("reset ready", {63'd0, outReady}, 64'd1);
        check("reset data", {32'd0, outData}, 64'd0);

        // rst must win over a simultaneous trigger.
        inTrigger = 1'b1;
        inData    = 64'd5;
        tick();
        inTrigger = 1'b0;
        check("rst priority ready", {63'd0, outReady}, 64'd1);
        check("rst priority data", {32'd0, outData}, 64'd0);
        rst = 1'b0;
        tick();
        check("idle ready", {63'd0, outReady}, 64'd1);

        convert("zero", 64'd0, 32'h0000_0000, 0);
        convert("one", 64'd1, 32'h3F80_0000, 65);
        convert("minus one", 64'hFFFF_FFFF_FFFF_FFFF, 32'hBF80_0000, 65);

        // Rounding is tested at 2^24 + {1, 3, 5}. The leading one sits at
        // bit 24, so lz = 39 and the result arrives on edge 41.
        convert("tie even 2^24+1", 64'd16777217, 32'h4B80_0000, 41);
        convert("tie up 2^24+3", 64'd16777219, 32'h4B80_0002, 41);
        convert("tie even 2^24+5", 64'd16777221, 32'h4B80_0002, 41);

        convert("max pos carry", 64'h7FFF_FFFF_FFFF_FFFF, 32'h5F00_0000, 3);
        convert("min neg", 64'h8000_0000_0000_0000, 32'hDF00_0000, 2);
        convert("minus 1000", -64'sd1000, 32'hC47A_0000, 56);

        // The result must stay stable while idle.
        held = outData;
        repeat (5) tick();
        check("idle hold ready", {63'd0, outReady}, 64'd1);
        check("idle hold data", {32'd0, outData}, {32'd0, held});

        // Retrigger: start 1, then replace it with 1000 after 10 cycles.
        inTrigger = 1'b1;
        inData    = 64'd1;
        tick();
        inTrigger = 1'b0;
        check("busy data held", {32'd0, outData}, {32'd0, held});
        repeat (10) tick();
        check("busy ready low", {63'd0, outReady}, 64'd0);
        convert("retrigger 1000", 64'd1000, 32'h447A_0000, 56);
        // The aborted operand must not complete later.
        spurious = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (!outReady || outData !== 32'h447A_0000) spurious = 1'b1;
        end
        check("no late completion of aborted op", {63'd0, spurious}, 64'd0);

        // Reset abort in the middle of a conversion.
        inTrigger = 1'b1;
        inData    = 64'h1234;
        tick();
        inTrigger = 1'b0;
        repeat (4) tick();
        check("pre-abort busy", {63'd0, outReady}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort ready", {63'd0, outReady}, 64'd1);
        check("abort data", {32'd0, outData}, 64'd0);
        spurious = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (!outReady || outData !== 32'd0) spurious = 1'b1;
        end
        check("no completion after reset", {63'd0, spurious}, 64'd0);

        // Zero also works directly after the reset.
        n = 0;
        convert("zero after reset", 64'd0, 32'h0000_0000, n);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
